melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
- REQ-001 SHALL have parameter BEAT_CYCLES, default 25_000_000; clk cycles per beat (0.25 s at 100 MHz).
- REQ-002 SHALL have parameter GAP_CYCLES, default 2_500_000; silent clk cycles inserted after every note.
- REQ-003 SHALL have parameter SONG_LEN, default 32; number of ROM entries, max 64.
- REQ-004 SHALL have port clk, input, 1; single system clock, all logic on posedge.
- REQ-005 SHALL have port rst_n, input, 1; asynchronous active-low reset.
- REQ-006 SHALL have port start, input, 1; play request, level-sampled each clk.
- REQ-007 SHALL have port stop, input, 1; abort request, level-sampled each clk.
- REQ-008 SHALL have port level_in, input, 4; volume captured on start acceptance.
- REQ-009 SHALL have port note, output, 4; note code to tone generator (0 = silent, 1..7 = do..si).
- REQ-010 SHALL have port level, output, 4; volume to tone generator.
- REQ-011 SHALL have port busy, output, 1; high in PLAY or GAP.
- REQ-012 SHALL have port done, output, 1; one-cycle pulse at end of song.
- REQ-013 SHALL have port step_idx, output, 6; current ROM index.

Function
- REQ-014 SHALL implement FSM states IDLE, PLAY, GAP, DONE; all outputs registered.
- REQ-015 ROM entry SHALL be 8 bits {note[3:0], beats[3:0]}; beats==0 is the end marker; note>7 SHALL be output as 0 (rest).
- REQ-016 IDLE: start=1 and stop=0 SHALL capture level_in, set step_idx=0, and enter PLAY (or DONE if entry 0 is an end marker) on the next edge.
- REQ-017 PLAY SHALL hold note=entry.note and level=captured level for exactly beats*BEAT_CYCLES cycles, then enter GAP.
- REQ-018 GAP SHALL drive note=0 for exactly GAP_CYCLES cycles, then increment step_idx and enter PLAY for the next entry.
- REQ-019 If the next entry is an end marker or step_idx+1==SONG_LEN, GAP SHALL exit to DONE instead of PLAY.
- REQ-020 DONE SHALL last one cycle with done=1, note=0, level=0, busy=0, then enter IDLE.
- REQ-021 stop=1 in any state SHALL force IDLE on the next edge with note=0, level=0, busy=0, and no done pulse; stop wins over start in the same cycle.
- REQ-022 start while busy SHALL be ignored; level_in changes mid-song SHALL not affect level.
- REQ-023 The cycle counter SHALL be 32 bits unsigned; the beat product SHALL be computed without overflow for beats<=15.
- REQ-024 In IDLE and DONE, note and level SHALL be 0.

Reset
- REQ-025 rst_n=0 SHALL immediately force state=IDLE, note=0, level=0, busy=0, done=0, step_idx=0, and counters=0, regardless of clk.
- REQ-026 Reset asserted mid-song SHALL abandon the song; after release, the block SHALL wait for a new start.

Configuration
- REQ-027 With MELODY_LOOP_EN defined, end-of-song SHALL pulse done for one cycle while staying busy, and SHALL wrap step_idx to 0 and re-enter PLAY; only stop or reset SHALL end playback.
- REQ-028 Without MELODY_LOOP_EN, end-of-song SHALL follow REQ-019/REQ-020.

Structure
- REQ-029 Package melody_pkg SHALL hold the state enum, the ROM-entry struct, NOTE_REST=0, and the default BEAT_CYCLES/GAP_CYCLES/SONG_LEN constants.
- REQ-030 Sub-module melody_rom SHALL map a 6-bit index combinationally to an 8-bit entry; the sequencer registers its outputs.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2, ROM = {1,2},{3,1},{0,1},{9,1},{x,0})
- REQ-031 Pulse start with level_in=9 -> note=1 for 8 cycles, 0 for 2, 3 for 4, 0 for 2, 0 for 4 (rest), 0 for 2, 0 for 4 (9 clipped), 0 for 2, then done for 1 cycle; level=9 during PLAY.
- REQ-032 Assert stop during the second note -> next cycle note=0, busy=0, no done pulse; a new start replays from step_idx=0.
- REQ-033 Raise start and stop together in IDLE -> stays IDLE, busy=0.
- REQ-034 Change level_in to 3 and pulse start mid-song -> level stays 9, timing unchanged.
- REQ-035 Assert rst_n=0 asynchronously mid-GAP -> all outputs 0 before the next clk edge.
- REQ-036 With MELODY_LOOP_EN -> done pulses once per pass, busy stays 1, step_idx wraps 3->0.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer.
// Looping playback is selected at build time with MELODY_LOOP_EN.
package melody_pkg;

    localparam int unsigned DEF_BEAT_CYCLES = 25_000_000;
    localparam int unsigned DEF_GAP_CYCLES  = 2_500_000;
    localparam int unsigned DEF_SONG_LEN    = 32;
    localparam int unsigned IDX_W           = 6;
    localparam int unsigned CNT_W           = 32;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_MAX  = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [3:0] note;
        logic [3:0] beats;
    } rom_entry_t;

    // Codes above si are not playable and become rests.
    function automatic logic [3:0] clip_note(input logic [3:0] n);
        return (n > NOTE_MAX) ? NOTE_REST : n;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Song table: 6-bit index to {note, beats}; beats == 0 marks the end of the song.
module melody_rom (
    input  logic [5:0] addr_i,
    output logic [7:0] entry_o_c
);

    always_comb begin
        entry_o_c = 8'h00;
        case (addr_i)
            6'd0:    entry_o_c = {4'd1, 4'd2};
            6'd1:    entry_o_c = {4'd3, 4'd1};
            6'd2:    entry_o_c = {4'd0, 4'd1};
            6'd3:    entry_o_c = {4'd9, 4'd1};
            default: entry_o_c = 8'h00;
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// Plays the melody ROM as timed notes separated by silent gaps.
// Define MELODY_LOOP_EN to repeat the song until stop or reset.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned BEAT_CYCLES = DEF_BEAT_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned SONG_LEN    = DEF_SONG_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] level_in,
    output logic [3:0] note,
    output logic [3:0] level,
    output logic       busy,
    output logic       done,
    output logic [5:0] step_idx
);

`ifdef MELODY_LOOP_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         cap_q, cap_d;
    logic [3:0]         note_q, note_d;
    logic [3:0]         level_q, level_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   step_q, step_d;

    logic [7:0]         rom_raw_c;
    rom_entry_t         entry_c;
    logic [IDX_W-1:0]   rom_addr_c;
    logic [IDX_W:0]     next_idx_c;
    logic               last_c;
    logic [CNT_W-1:0]   play_len_m1_c;
    logic [CNT_W-1:0]   gap_len_m1_c;
    logic               load_play;
    logic               enter_done;

    // GAP looks ahead at the next entry; every other state needs entry 0.
    assign next_idx_c    = (IDX_W+1)'({1'b0, step_q}) + (IDX_W+1)'(1);
    assign rom_addr_c    = (state_q == ST_GAP) ? next_idx_c[IDX_W-1:0] : IDX_W'(0);
    assign entry_c       = rom_entry_t'(rom_raw_c);
    assign last_c        = (next_idx_c == (IDX_W+1)'(SONG_LEN)) || (entry_c.beats == 4'd0);
    assign play_len_m1_c = 32'(entry_c.beats) * 32'(BEAT_CYCLES) - 32'd1;
    assign gap_len_m1_c  = 32'(GAP_CYCLES) - 32'd1;

    melody_rom u_rom (
        .addr_i    (rom_addr_c),
        .entry_o_c (rom_raw_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        note_d     = note_q;
        level_d    = level_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        step_d     = step_q;
        load_play  = 1'b0;
        enter_done = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            note_d  = NOTE_REST;
            level_d = 4'd0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cap_d  = level_in;
                        step_d = '0;
                        if (entry_c.beats == 4'd0) enter_done = 1'b1;
                        else                       load_play  = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_GAP;
                        note_d  = NOTE_REST;
                        cnt_d   = gap_len_m1_c;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 32'd1;
                    end else if (last_c) begin
                        enter_done = 1'b1;
                    end else begin
                        step_d    = next_idx_c[IDX_W-1:0];
                        load_play = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (LOOP_EN && (entry_c.beats != 4'd0)) begin
                        step_d    = '0;
                        load_play = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        note_d  = NOTE_REST;
                        level_d = 4'd0;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (enter_done) begin
                state_d = ST_DONE;
                cnt_d   = '0;
                done_d  = 1'b1;
                note_d  = NOTE_REST;
                level_d = 4'd0;
                busy_d  = LOOP_EN;
            end
            if (load_play) begin
                state_d = ST_PLAY;
                cnt_d   = play_len_m1_c;
                note_d  = clip_note(entry_c.note);
                level_d = cap_d;
                busy_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cap_q   <= 4'd0;
            note_q  <= NOTE_REST;
            level_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            note_q  <= note_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            step_q  <= step_d;
        end
    end

    assign note     = note_q;
    assign level    = level_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: two instances (full song and SONG_LEN=2) checked every
// cycle against a per-song expected-timeline model; honours MELODY_LOOP_EN.
module tb_melody_sequencer;

    localparam int BEAT = 4;
    localparam int GAP  = 2;
`ifdef MELODY_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] note;
        logic [3:0] level;
        logic       busy;
        logic       done;
        logic [5:0] step;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] level_in = 4'd0;

    logic [3:0] note0, level0, note1, level1;
    logic       busy0, done0, busy1, done1;
    logic [5:0] step0, step1;

    int   total = 0;
    int   bad = 0;
    int   song_len [2] = '{32, 2};
    logic [7:0] rom_tb [0:63];
    obs_t mq [2][$];
    obs_t exp_o [2] = '{16'h0, 16'h0};
    logic [3:0] cap [2] = '{4'd0, 4'd0};
    bit   looping [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .level_in(level_in),
        .note(note0), .level(level0), .busy(busy0), .done(done0), .step_idx(step0)
    );

    melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .level_in(level_in),
        .note(note1), .level(level1), .busy(busy1), .done(done1), .step_idx(step1)
    );

    function automatic obs_t mk(input int n, input int l, input int b, input int dn, input int s);
        obs_t o;
        o.note  = 4'(n);
        o.level = 4'(l);
        o.busy  = 1'(b);
        o.done  = 1'(dn);
        o.step  = 6'(s);
        return o;
    endfunction

    function automatic obs_t act(input int d);
        obs_t o;
        if (d == 0) o = {note0, level0, busy0, done0, step0};
        else        o = {note1, level1, busy1, done1, step1};
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t: got note=%0d level=%0d busy=%0d done=%0d step=%0d, want note=%0d level=%0d busy=%0d done=%0d step=%0d",
                     name, $time, got.note, got.level, got.busy, got.done, got.step,
                     want.note, want.level, want.busy, want.done, want.step);
        end
    endtask

    // Whole-song expected timeline, one element per clock, ending with the done cycle.
    task automatic build(input int d, input logic [3:0] lvl);
        int last;
        logic [3:0] bt;
        logic [3:0] nt;
        last = 0;
        for (int i = 0; i < song_len[d]; i++) begin
            bt = rom_tb[i][3:0];
            if (bt == 4'd0) break;
            nt = (rom_tb[i][7:4] > 4'd7) ? 4'd0 : rom_tb[i][7:4];
            repeat (int'(bt) * BEAT) mq[d].push_back(mk(nt, lvl, 1, 0, i));
            repeat (GAP) mq[d].push_back(mk(0, lvl, 1, 0, i));
            last = i;
        end
        mq[d].push_back(mk(0, 0, LOOP, 1, last));
    endtask

    task automatic model_step(input int d);
        obs_t idle_o;
        idle_o = mk(0, 0, 0, 0, exp_o[d].step);
        if (stop) begin
            mq[d].delete();
            looping[d] = 1'b0;
            exp_o[d] = idle_o;
            return;
        end
        if (mq[d].size() == 0) begin
            if (looping[d]) begin
                build(d, cap[d]);
            end else if (start && !exp_o[d].busy && !exp_o[d].done) begin
                cap[d] = level_in;
                build(d, level_in);
                looping[d] = LOOP;
            end
        end
        exp_o[d] = (mq[d].size() != 0) ? mq[d].pop_front() : idle_o;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                mq[d].delete();
                looping[d] = 1'b0;
                exp_o[d] = mk(0, 0, 0, 0, 0);
            end else begin
                model_step(d);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("cyc_dut0", act(0), exp_o[0]);
        check("cyc_dut1", act(1), exp_o[1]);
    end

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom_tb[i] = 8'h00;
        rom_tb[0] = 8'h12;
        rom_tb[1] = 8'h31;
        rom_tb[2] = 8'h01;
        rom_tb[3] = 8'h91;

        repeat (3) @(negedge clk);
        check("reset_dut0", act(0), mk(0, 0, 0, 0, 0));
        check("reset_dut1", act(1), mk(0, 0, 0, 0, 0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full song; a second start with a new level arrives mid-song.
        level_in = 4'd9;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            case (k)
                1:  check("song_k1", act(0), mk(1, 9, 1, 0, 0));
                8:  check("song_k8", act(0), mk(1, 9, 1, 0, 0));
                9:  check("song_gap1", act(0), mk(0, 9, 1, 0, 0));
                11: check("song_k11", act(0), mk(3, 9, 1, 0, 1));
                12: begin level_in = 4'd3; start = 1'b1; end
                13: check("midstart_k13", act(0), mk(3, 9, 1, 0, 1));
                15: check("midstart_gap", act(0), mk(0, 9, 1, 0, 1));
                16: check("len2_lastgap", act(1), mk(0, 9, 1, 0, 1));
                17: begin
                        check("song_rest", act(0), mk(0, 9, 1, 0, 2));
                        check("len2_done", act(1), mk(0, 0, LOOP, 1, 1));
                    end
                23: check("song_clip", act(0), mk(0, 9, 1, 0, 3));
                29: check("song_done", act(0), mk(0, 0, LOOP, 1, 3));
                30: begin
                        if (LOOP) check("loop_wrap", act(0), mk(1, 9, 1, 0, 0));
                        else      check("after_done", act(0), mk(0, 0, 0, 0, 3));
                    end
                default: ;
            endcase
        end
        pulse_stop();
        repeat (2) @(negedge clk);

        // Stop during the second note, then replay from the top with a new level.
        level_in = 4'd9;
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_dut0", act(0), mk(0, 0, 0, 0, 1));
        check("stop_dut1", act(1), mk(0, 0, 0, 0, 1));
        @(negedge clk);
        check("stop_nodone", act(0), mk(0, 0, 0, 0, 1));
        level_in = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("replay_k1", act(0), mk(1, 5, 1, 0, 0));
        pulse_stop();

        // start and stop together in idle.
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        check("start_stop", act(0), mk(0, 0, 0, 0, 0));
        @(negedge clk);
        check("start_stop_hold", act(0), mk(0, 0, 0, 0, 0));

        // Asynchronous reset in the first gap.
        level_in = 4'd9;
        start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        check("async_rst0", act(0), mk(0, 0, 0, 0, 0));
        check("async_rst1", act(1), mk(0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", act(0), mk(0, 0, 0, 0, 0));

        // Random traffic with occasional stop and reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 59) == 0);
            level_in = 4'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        stop = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
